// File: rtl/game_over_animator.sv
`default_nettype none
// game_over_animator: delayed, frame-stepped "game over" banner overlay producing sprite ROM addresses.
// Optional macro GAME_OVER_BLINK_EN blinks the held banner. Rev 1.0
module game_over_animator #(
   parameter int WIDTH           = 73,
   parameter int HEIGHT          = 9,
   parameter int NUM_FRAMES      = 2,
   parameter int TICKS_PER_FRAME = 8,
   parameter int DELAY_FRAMES    = 30,
   parameter int X_LIMIT         = 575,
   parameter int Y_LIMIT         = 239
) (
   input  logic                                        pixel_clk_in,
   input  logic                                        rst_in,
   input  logic [10:0]                                 hcount_in,
   input  logic [9:0]                                  vcount_in,
   input  logic                                        new_frame_in,
   input  logic                                        collision_in,
   input  logic                                        clear_in,
   input  logic [12:0]                                 x_in,
   input  logic [9:0]                                  y_in,
   input  logic [11:0]                                 offset_background,
   output logic [$clog2(WIDTH*HEIGHT*NUM_FRAMES)-1:0]  image_addr,
   output logic                                        in_sprite,
   output logic                                        active_out,
   output logic                                        done_out
);

   localparam int c_AW = $clog2(WIDTH * HEIGHT * NUM_FRAMES);
   localparam int c_FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int c_TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
   localparam int c_DW = (DELAY_FRAMES > 0) ? $clog2(DELAY_FRAMES + 1) : 1;

   localparam logic [c_FW-1:0] c_LAST_FRAME = c_FW'(NUM_FRAMES - 1);
   localparam logic [c_TW-1:0] c_LAST_TICK  = c_TW'(TICKS_PER_FRAME - 1);
   localparam logic [c_DW-1:0] c_LAST_DELAY = c_DW'(DELAY_FRAMES - 1);
   localparam logic [13:0]     c_WIDTH14    = 14'(WIDTH);
   localparam logic [13:0]     c_HEIGHT14   = 14'(HEIGHT);
   localparam logic [31:0]     c_XLIM       = 32'(X_LIMIT);
   localparam logic [31:0]     c_YLIM       = 32'(Y_LIMIT);
   localparam logic [c_AW-1:0] c_ROW_STRIDE = c_AW'(WIDTH);
   localparam logic [c_AW-1:0] c_FRM_STRIDE = c_AW'(WIDTH * HEIGHT);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ANIMATE, S_HOLD} state_t;

   state_t          r_state_q;
   logic [c_DW-1:0] r_delay_q;
   logic [c_TW-1:0] r_tick_q;
   logic [c_FW-1:0] r_frame_q;
   logic [12:0]     r_x_q;
   logic [9:0]      r_y_q;
   logic [11:0]     r_offset_q;
   logic            r_active_q;
   logic            r_done_q;
   logic            r_sprite_q;
   logic [c_AW-1:0] r_addr_q;

   logic [13:0]     w_col, w_row, w_x_lo, w_x_hi, w_y_lo, w_y_hi, w_dx, w_dy;
   logic            w_hit_d;
   logic            w_show;
   logic [c_AW-1:0] w_addr_d;

`ifdef GAME_OVER_BLINK_EN
   logic            r_blink_q;
   logic [3:0]      r_blink_cnt_q;
   assign w_show = (r_state_q != S_HOLD) || r_blink_q;
`else
   assign w_show = 1'b1;
`endif

   // Banner bounds live in world space; the column is un-scrolled through the per-frame shadow offset.
   assign w_col  = 14'(hcount_in) + 14'(r_offset_q);
   assign w_row  = 14'(vcount_in);
   assign w_x_lo = 14'(r_x_q);
   assign w_x_hi = 14'(r_x_q) + c_WIDTH14;
   assign w_y_lo = 14'(r_y_q);
   assign w_y_hi = 14'(r_y_q) + c_HEIGHT14;
   assign w_dx   = w_col - w_x_lo;
   assign w_dy   = w_row - w_y_lo;

   assign w_hit_d = r_active_q
                    && (w_col >= w_x_lo) && (w_col < w_x_hi)
                    && (w_row >= w_y_lo) && (w_row < w_y_hi)
                    && (32'(hcount_in) <= c_XLIM)
                    && (32'(vcount_in) <= c_YLIM);

   assign w_addr_d = w_hit_d ? (c_AW'(w_dx) + c_AW'(w_dy) * c_ROW_STRIDE
                                + c_AW'(r_frame_q) * c_FRM_STRIDE)
                             : '0;

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         r_state_q     <= S_IDLE;
         r_delay_q     <= '0;
         r_tick_q      <= '0;
         r_frame_q     <= '0;
         r_x_q         <= '0;
         r_y_q         <= '0;
         r_offset_q    <= '0;
         r_active_q    <= 1'b0;
         r_done_q      <= 1'b0;
         r_sprite_q    <= 1'b0;
         r_addr_q      <= '0;
`ifdef GAME_OVER_BLINK_EN
         r_blink_q     <= 1'b0;
         r_blink_cnt_q <= '0;
`endif
      end else begin
         r_done_q   <= 1'b0;
         r_sprite_q <= w_hit_d && w_show;
         r_addr_q   <= w_addr_d;
         if (new_frame_in) begin
            r_offset_q <= offset_background;
         end
         if (clear_in) begin
            r_state_q  <= S_IDLE;
            r_active_q <= 1'b0;
         end else begin
            case (r_state_q)
               S_IDLE: begin
                  if (collision_in) begin
                     r_state_q <= S_ARMED;
                     r_x_q     <= x_in;
                     r_y_q     <= y_in;
                     r_delay_q <= '0;
                  end
               end
               S_ARMED: begin
                  if (DELAY_FRAMES == 0 || (new_frame_in && r_delay_q == c_LAST_DELAY)) begin
                     r_state_q  <= S_ANIMATE;
                     r_active_q <= 1'b1;
                     r_frame_q  <= '0;
                     r_tick_q   <= '0;
                  end else if (new_frame_in) begin
                     r_delay_q <= r_delay_q + c_DW'(1);
                  end
               end
               S_ANIMATE: begin
                  if (new_frame_in) begin
                     if (r_tick_q == c_LAST_TICK) begin
                        r_tick_q <= '0;
                        if (r_frame_q == c_LAST_FRAME) begin
                           r_state_q <= S_HOLD;
                           r_done_q  <= 1'b1;
`ifdef GAME_OVER_BLINK_EN
                           r_blink_q     <= 1'b1;
                           r_blink_cnt_q <= '0;
`endif
                        end else begin
                           r_frame_q <= r_frame_q + c_FW'(1);
                        end
                     end else begin
                        r_tick_q <= r_tick_q + c_TW'(1);
                     end
                  end
               end
               S_HOLD: begin
`ifdef GAME_OVER_BLINK_EN
                  if (new_frame_in) begin
                     r_blink_cnt_q <= r_blink_cnt_q + 4'd1;
                     if (r_blink_cnt_q == 4'd15) begin
                        r_blink_q <= ~r_blink_q;
                     end
                  end
`endif
               end
               default: begin
                  r_state_q  <= S_IDLE;
                  r_active_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign image_addr = r_addr_q;
   assign in_sprite  = r_sprite_q;
   assign active_out = r_active_q;
   assign done_out   = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_game_over_animator.sv
`default_nettype none
// tb_game_over_animator: scoreboard bench for the default (solid banner) build of game_over_animator.
// Rev 1.0
module tb_game_over_animator;

   localparam int W  = 73;
   localparam int H  = 9;
   localparam int NF = 2;
   localparam int T  = 8;
   localparam int D  = 30;
   localparam int XL = 575;
   localparam int YL = 239;

   logic        clk = 1'b0;
   logic        rst = 1'b0, nf = 1'b0, coll = 1'b0, clr = 1'b0;
   logic [10:0] hc = '0;
   logic [9:0]  vc = '0;
   logic [12:0] xi = '0;
   logic [9:0]  yi = '0;
   logic [11:0] off = '0;
   logic [10:0] addr;
   logic        spr, act, done;

   always #5 clk = ~clk;

   game_over_animator dut (
      .pixel_clk_in      (clk),
      .rst_in            (rst),
      .hcount_in         (hc),
      .vcount_in         (vc),
      .new_frame_in      (nf),
      .collision_in      (coll),
      .clear_in          (clr),
      .x_in              (xi),
      .y_in              (yi),
      .offset_background (off),
      .image_addr        (addr),
      .in_sprite         (spr),
      .active_out        (act),
      .done_out          (done)
   );

   typedef struct {
      logic        spr;
      logic [10:0] addr;
      logic        act;
      logic        done;
   } exp_t;

   typedef struct {
      int h, v, o;
      bit n, c, cl, r;
   } step_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: pulses counted since the sequence was armed decide phase and frame.
   bit m_seq = 1'b0;
   int m_p = 0, m_xl = 0, m_yl = 0, m_off = 0;

   function automatic step_t mk(int h, int v, bit n, bit c, bit cl, bit r, int o);
      step_t s;
      s.h = h; s.v = v; s.n = n; s.c = c; s.cl = cl; s.r = r; s.o = o;
      return s;
   endfunction

   task automatic drive(input step_t st);
      exp_t e;
      int   col, fr;
      bit   m_act, hit;
      @(negedge clk);
      rst = st.r; hc = 11'(st.h); vc = 10'(st.v); nf = st.n; coll = st.c; clr = st.cl;
      off = 12'(st.o);
      m_act = m_seq && (m_p >= D);
      fr = m_act ? (m_p - D) / T : 0;
      if (fr > NF - 1) fr = NF - 1;
      col = st.h + m_off;
      hit = m_act && col >= m_xl && col < m_xl + W && st.v >= m_yl && st.v < m_yl + H
            && st.h <= XL && st.v <= YL;
      e.spr  = st.r ? 1'b0 : hit;
      e.addr = (st.r || !hit) ? 11'd0 : 11'((col - m_xl) + (st.v - m_yl) * W + fr * W * H);
      e.done = 1'b0;
      if (st.r) begin
         m_seq = 1'b0; m_p = 0; m_xl = 0; m_yl = 0; m_off = 0;
      end else begin
         if (st.n) m_off = st.o;
         if (st.cl) begin
            m_seq = 1'b0;
         end else if (!m_seq) begin
            if (st.c) begin
               m_seq = 1'b1; m_p = 0; m_xl = int'(xi); m_yl = int'(yi);
            end
         end else if (st.n) begin
            m_p++;
            if (m_p == D + NF * T) e.done = 1'b1;
         end
      end
      e.act = m_seq && (m_p >= D);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step_t s[$];
      exp_t  e;
      s.push_back(mk(0, 0, 0, 0, 0, 1, 0));
      s.push_back(mk(100, 50, 1, 1, 0, 1, 0));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL reset[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if ({spr, addr, act, done} !== {e.spr, e.addr, e.act, e.done}) begin
               errors++;
               $display("FAIL reset[%0d]: got spr=%0b addr=%0d act=%0b done=%0b want spr=%0b addr=%0d act=%0b done=%0b",
                        i, spr, addr, act, done, e.spr, e.addr, e.act, e.done);
            end
         end
      end
   endtask

   task automatic test_arm();
      step_t s[$];
      exp_t  e;
      xi = 13'd100; yi = 10'd50;
      s.push_back(mk(100, 50, 1, 1, 0, 0, 0));
      for (int k = 0; k < D; k++) begin
         s.push_back(mk(100, 50, 1, 0, 0, 0, 0));
         s.push_back(mk(100, 50, 0, 1, 0, 0, 0));
      end
      s.push_back(mk(99, 50, 0, 0, 0, 0, 0));
      s.push_back(mk(100, 49, 0, 0, 0, 0, 0));
      s.push_back(mk(100, 50, 0, 0, 0, 0, 0));
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL arm[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if ({spr, addr, act, done} !== {e.spr, e.addr, e.act, e.done}) begin
               errors++;
               $display("FAIL arm[%0d]: got spr=%0b addr=%0d act=%0b done=%0b want spr=%0b addr=%0d act=%0b done=%0b",
                        i, spr, addr, act, done, e.spr, e.addr, e.act, e.done);
            end
         end
      end
   endtask

   task automatic test_offset();
      step_t s[$];
      exp_t  e;
      s.push_back(mk(80, 50, 0, 0, 0, 0, 20));
      s.push_back(mk(100, 50, 0, 0, 0, 0, 20));
      s.push_back(mk(80, 50, 1, 0, 0, 0, 20));
      s.push_back(mk(80, 50, 0, 0, 0, 0, 20));
      s.push_back(mk(100, 50, 0, 0, 0, 0, 20));
      s.push_back(mk(0, 0, 1, 0, 0, 0, 0));
      s.push_back(mk(100, 50, 0, 0, 0, 0, 0));
      s.push_back(mk(80, 50, 0, 0, 0, 0, 0));
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL offset[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if ({spr, addr, act, done} !== {e.spr, e.addr, e.act, e.done}) begin
               errors++;
               $display("FAIL offset[%0d]: got spr=%0b addr=%0d act=%0b done=%0b want spr=%0b addr=%0d act=%0b done=%0b",
                        i, spr, addr, act, done, e.spr, e.addr, e.act, e.done);
            end
         end
      end
   endtask

   task automatic test_animate();
      step_t s[$];
      exp_t  e;
      s.push_back(mk(172, 58, 0, 0, 0, 0, 0));
      s.push_back(mk(173, 58, 0, 0, 0, 0, 0));
      s.push_back(mk(100, 59, 0, 0, 0, 0, 0));
      s.push_back(mk(172, 50, 0, 0, 0, 0, 0));
      for (int k = 0; k < 6; k++) begin
         s.push_back(mk(172, 58, 1, 0, 0, 0, 0));
         s.push_back(mk(100, 50, 0, 0, 0, 0, 0));
      end
      s.push_back(mk(172, 58, 0, 0, 0, 0, 0));
      s.push_back(mk(173, 58, 0, 0, 0, 0, 0));
      s.push_back(mk(100, 50, 0, 0, 0, 0, 0));
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL animate[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if ({spr, addr, act, done} !== {e.spr, e.addr, e.act, e.done}) begin
               errors++;
               $display("FAIL animate[%0d]: got spr=%0b addr=%0d act=%0b done=%0b want spr=%0b addr=%0d act=%0b done=%0b",
                        i, spr, addr, act, done, e.spr, e.addr, e.act, e.done);
            end
         end
      end
   endtask

   task automatic test_done();
      step_t s[$];
      exp_t  e;
      int    done_seen = 0;
      for (int k = 0; k < 28; k++) begin
         s.push_back(mk(172, 58, 1, 0, 0, 0, 0));
         s.push_back(mk(100, 50, 0, 1, 0, 0, 0));
      end
      s.push_back(mk(172, 58, 0, 0, 0, 0, 0));
      foreach (s[i]) begin
         drive(s[i]);
         if (done === 1'b1) done_seen++;
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL done[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if ({spr, addr, act, done} !== {e.spr, e.addr, e.act, e.done}) begin
               errors++;
               $display("FAIL done[%0d]: got spr=%0b addr=%0d act=%0b done=%0b want spr=%0b addr=%0d act=%0b done=%0b",
                        i, spr, addr, act, done, e.spr, e.addr, e.act, e.done);
            end
         end
      end
      checks++;
      if (done_seen !== 1) begin
         errors++; $display("FAIL done_count: got %0d pulses want 1", done_seen);
      end
   endtask

   task automatic test_clear();
      step_t s[$];
      exp_t  e;
      s.push_back(mk(100, 50, 0, 1, 1, 0, 0));
      s.push_back(mk(100, 50, 0, 0, 0, 0, 0));
      for (int k = 0; k < D + 1; k++) begin
         s.push_back(mk(100, 50, 1, 0, 0, 0, 0));
         s.push_back(mk(100, 50, 0, 0, 0, 0, 0));
      end
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL clear[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if ({spr, addr, act, done} !== {e.spr, e.addr, e.act, e.done}) begin
               errors++;
               $display("FAIL clear[%0d]: got spr=%0b addr=%0d act=%0b done=%0b want spr=%0b addr=%0d act=%0b done=%0b",
                        i, spr, addr, act, done, e.spr, e.addr, e.act, e.done);
            end
         end
      end
   endtask

   task automatic test_limits();
      step_t s[$];
      exp_t  e;
      xi = 13'd540; yi = 10'd235;
      s.push_back(mk(0, 0, 0, 1, 0, 0, 0));
      for (int k = 0; k < D; k++) begin
         s.push_back(mk(0, 0, 1, 0, 0, 0, 0));
         s.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      end
      s.push_back(mk(540, 235, 0, 0, 0, 0, 0));
      s.push_back(mk(575, 239, 0, 0, 0, 0, 0));
      s.push_back(mk(576, 239, 0, 0, 0, 0, 0));
      s.push_back(mk(575, 240, 0, 0, 0, 0, 0));
      s.push_back(mk(560, 243, 0, 0, 0, 0, 0));
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL limits[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if ({spr, addr, act, done} !== {e.spr, e.addr, e.act, e.done}) begin
               errors++;
               $display("FAIL limits[%0d]: got spr=%0b addr=%0d act=%0b done=%0b want spr=%0b addr=%0d act=%0b done=%0b",
                        i, spr, addr, act, done, e.spr, e.addr, e.act, e.done);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      step_t s[$];
      exp_t  e;
      for (int k = 0; k < 3; k++) begin
         s.push_back(mk(545, 236, 1, 0, 0, 0, 0));
         s.push_back(mk(545, 236, 0, 0, 0, 0, 0));
      end
      s.push_back(mk(545, 236, 0, 0, 0, 1, 0));
      s.push_back(mk(545, 236, 0, 0, 0, 0, 0));
      for (int k = 0; k < 20; k++) begin
         s.push_back(mk(545, 236, 1, 0, 0, 0, 0));
         s.push_back(mk(545, 236, 0, 0, 0, 0, 0));
      end
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL reset_mid[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if ({spr, addr, act, done} !== {e.spr, e.addr, e.act, e.done}) begin
               errors++;
               $display("FAIL reset_mid[%0d]: got spr=%0b addr=%0d act=%0b done=%0b want spr=%0b addr=%0d act=%0b done=%0b",
                        i, spr, addr, act, done, e.spr, e.addr, e.act, e.done);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t s[$];
      exp_t  e;
      xi = 13'd100; yi = 10'd50;
      s.push_back(mk(100, 50, 0, 1, 0, 0, 0));
      for (int k = 0; k < D; k++) begin
         s.push_back(mk(100, 50, 1, 0, 0, 0, 0));
         s.push_back(mk(100, 50, 0, 0, 0, 0, 0));
      end
      s.push_back(mk(172, 58, 0, 0, 0, 0, 0));
      foreach (s[i]) begin
         drive(s[i]);
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL back_to_back[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if ({spr, addr, act, done} !== {e.spr, e.addr, e.act, e.done}) begin
               errors++;
               $display("FAIL back_to_back[%0d]: got spr=%0b addr=%0d act=%0b done=%0b want spr=%0b addr=%0d act=%0b done=%0b",
                        i, spr, addr, act, done, e.spr, e.addr, e.act, e.done);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_arm();
      test_offset();
      test_animate();
      test_done();
      test_clear();
      test_limits();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
